spi_mem_peripheral: RTL and testbench

- Parametrised SPI peripheral (mode 0, MSB first) connecting the nRF host to the FPGA.
- Decodes a one-byte opcode and returns the chip ID, an 8-bit debug register, or a DBG_W-bit debug word.
- Also returns auto-incrementing burst reads from a MEM_W x MEM_DEPTH debug RAM with a host-programmable start address.
- Sits between the top-level SPI pins and the debug/capture RAM read port.

---
 rtl/spi_mem_peripheral.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_mem_peripheral.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_peripheral.sv
// SPI mode-0 peripheral: opcode decode for chip ID / debug registers,
// address load and auto-incrementing burst reads from a debug RAM.
// Optional burst word counter and opcode 0xBD: define SPI_WORD_COUNT_EN.
module spi_mem_peripheral #(
  parameter logic [7:0]  CHIP_ID    = 8'hAA,
  parameter int unsigned DBG_W      = 32,
  parameter int unsigned MEM_W      = 30,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned MEM_DEPTH  = 2**ADDR_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              cs,
  input  logic              copi,
  output logic              cipo,
  input  logic [7:0]        debug8,
  input  logic [DBG_W-1:0]  debug_w,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [MEM_W-1:0]  rd_data
);

  localparam int unsigned MEM_BYTES  = (MEM_W + 7) / 8;
  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned MWB        = MEM_BYTES * 8;
  localparam int unsigned TX_W0      = (DBG_W > MWB) ? DBG_W : MWB;
  localparam int unsigned TX_W       = (TX_W0 > 16) ? TX_W0 : 16;

  typedef enum logic [2:0] {
    S_IDLE, S_OPCODE, S_RESP, S_ADDR, S_BURST, S_DRAIN
  } state_t;

  logic [1:0]            r_sck_s, r_cs_s, r_copi_s;
  logic                  r_sck_d, r_cs_d;
  state_t                r_state;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_byte_cnt;
  logic [7:0]            r_nbytes;
  logic [6:0]            r_sh;
  logic [ADDR_W-1:0]     r_acc;
  logic [ADDR_W-1:0]     r_addr_base;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_rd_en;
  logic [RD_LATENCY-1:0] r_rd_pipe;
  logic                  r_cap_to_tx;
  logic [TX_W-1:0]       r_tx;
  logic [TX_W-1:0]       r_prefetch;
  logic                  r_cipo;
`ifdef SPI_WORD_COUNT_EN
  logic [15:0]           r_word_cnt;
  logic [15:0]           r_last_words;
`endif

  logic                  w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [7:0]            w_opcode;
  logic [ADDR_W-1:0]     w_acc_next;
  logic [ADDR_W-1:0]     w_addr_mod;
  logic [MWB-1:0]        w_word;
  logic [TX_W-1:0]       w_word_tx;
  logic                  w_last_byte;

  assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s[1] & r_sck_d;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_opcode    = {r_sh, r_copi_s[1]};
  // Shifting into an ADDR_W-wide register drops excess upper payload bits.
  assign w_acc_next  = {r_acc[ADDR_W-2:0], r_copi_s[1]};
  assign w_addr_mod  = ADDR_W'(32'(w_acc_next) % MEM_DEPTH);
  assign w_word      = MWB'(rd_data);
  assign w_word_tx   = TX_W'(w_word) << (TX_W - MWB);
  assign w_last_byte = (r_byte_cnt == 8'(MEM_BYTES - 1));

  assign cipo    = r_cipo;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_s  <= '0;
      r_cs_s   <= '1;
      r_copi_s <= '0;
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[0], sck};
      r_cs_s   <= {r_cs_s[0], cs};
      r_copi_s <= {r_copi_s[0], copi};
      r_sck_d  <= r_sck_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  // Transaction FSM, response shifter, RAM fetch and prefetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_nbytes    <= '0;
      r_sh        <= '0;
      r_acc       <= '0;
      r_addr_base <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_pipe   <= '0;
      r_cap_to_tx <= 1'b0;
      r_tx        <= '0;
      r_prefetch  <= '0;
      r_cipo      <= 1'b0;
`ifdef SPI_WORD_COUNT_EN
      r_word_cnt   <= '0;
      r_last_words <= '0;
`endif
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_pipe <= RD_LATENCY'({r_rd_pipe, r_rd_en});
      // First fetch of a burst goes straight to the shifter, later ones wait.
      if (r_rd_pipe[RD_LATENCY-1]) begin
        if (r_cap_to_tx) begin
          r_tx        <= w_word_tx;
          r_cap_to_tx <= 1'b0;
        end else begin
          r_prefetch <= w_word_tx;
        end
      end

      if (w_cs_rise) begin
        r_state     <= S_IDLE;
        r_cipo      <= 1'b0;
        r_rd_en     <= 1'b0;
        r_rd_pipe   <= '0;
        r_cap_to_tx <= 1'b0;
        r_bit_cnt   <= '0;
        r_byte_cnt  <= '0;
`ifdef SPI_WORD_COUNT_EN
        if (r_state == S_BURST) r_last_words <= r_word_cnt;
        r_word_cnt <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state    <= S_OPCODE;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
              r_cipo     <= 1'b1;
            end
          end
          S_OPCODE: begin
            if (w_sck_rise) begin
              r_sh      <= w_opcode[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= '0;
                case (w_opcode)
                  8'h00: begin
                    r_tx     <= TX_W'(CHIP_ID) << (TX_W - 8);
                    r_nbytes <= 8'd1;
                    r_state  <= S_RESP;
                  end
                  8'hB8: begin
                    r_tx     <= TX_W'(debug8) << (TX_W - 8);
                    r_nbytes <= 8'd1;
                    r_state  <= S_RESP;
                  end
                  8'hB9: begin
                    r_tx     <= TX_W'(debug_w) << (TX_W - DBG_W);
                    r_nbytes <= 8'(DBG_W / 8);
                    r_state  <= S_RESP;
                  end
                  8'hBC: r_state <= S_ADDR;
                  8'hBA: begin
                    r_rd_addr   <= r_addr_base;
                    r_rd_en     <= 1'b1;
                    r_cap_to_tx <= 1'b1;
                    r_state     <= S_BURST;
                  end
`ifdef SPI_WORD_COUNT_EN
                  8'hBD: begin
                    r_tx     <= TX_W'(r_last_words) << (TX_W - 16);
                    r_nbytes <= 8'd2;
                    r_state  <= S_RESP;
                  end
`endif
                  default: r_state <= S_DRAIN;
                endcase
              end
            end
          end
          S_RESP: begin
            if (w_sck_fall) begin
              if (r_byte_cnt == r_nbytes) begin
                r_state <= S_DRAIN;
                r_cipo  <= 1'b1;
              end else begin
                r_cipo    <= r_tx[TX_W-1];
                r_tx      <= {r_tx[TX_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) r_byte_cnt <= r_byte_cnt + 8'd1;
              end
            end
          end
          S_ADDR: begin
            if (w_sck_rise) begin
              r_acc     <= w_acc_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
                if (r_byte_cnt == 8'(ADDR_BYTES - 1)) begin
                  r_addr_base <= w_addr_mod;
                  r_state     <= S_DRAIN;
                end
              end
            end
          end
          S_BURST: begin
            if (w_sck_fall) begin
              r_cipo <= r_tx[TX_W-1];
              // Fetch the next word while the last byte of this one shifts out.
              if (w_last_byte && r_bit_cnt == 3'd0) begin
                r_rd_addr <= (r_rd_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0
                                                                  : r_rd_addr + 1'b1;
                r_rd_en   <= 1'b1;
              end
              if (w_last_byte && r_bit_cnt == 3'd7) begin
                r_tx       <= r_prefetch;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
`ifdef SPI_WORD_COUNT_EN
                if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
`endif
              end else begin
                r_tx      <= {r_tx[TX_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) r_byte_cnt <= r_byte_cnt + 8'd1;
              end
            end
          end
          S_DRAIN: r_cipo <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_peripheral.sv
// Directed bench for spi_mem_peripheral: register-reply table plus
// hand-written address, burst, wrap, abort and reset sequences.
module tb_spi_mem_peripheral;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        copi = 1'b0;
  logic        cipo;
  logic [7:0]  debug8 = 8'h00;
  logic [31:0] debug_w = 32'h0;
  logic [17:0] rd_addr;
  logic        rd_en;
  logic [29:0] rd_data = '0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [17:0] addr_log[$];

  always #5 clk = ~clk;

  spi_mem_peripheral #(
    .CHIP_ID(8'hAA), .DBG_W(32), .MEM_W(30), .ADDR_W(18),
    .MEM_DEPTH(2**18), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs(cs), .copi(copi),
    .cipo(cipo), .debug8(debug8), .debug_w(debug_w), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data)
  );

  function automatic logic [29:0] ram_f(input logic [17:0] a);
    return {a[5:0], a, 6'h2B} ^ 30'h2A5A_5A5A;
  endfunction

  // One-cycle-latency RAM model and read-strobe monitor.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= ram_f(rd_addr);
      rd_cnt  <= rd_cnt + 1;
      addr_log.push_back(rd_addr);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      copi = tx[7-i];
      #HALF;
      sck = 1'b1;
      rx[7-i] = cipo;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF;
    cs = 1'b1;
    #(4*HALF);
  endtask

  task automatic load_addr(input logic [23:0] a);
    logic [7:0] rx;
    cs_start();
    spi_bits(8'hBC, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(a[23-8*i -: 8], 8, rx);
      check("addr_payload_cipo", rx, 8'hFF);
    end
    cs_end();
  endtask

  task automatic burst(input logic [17:0] start, input int nwords, input string tag);
    logic [7:0]  rx;
    logic [31:0] w;
    logic [17:0] a;
    cs_start();
    spi_bits(8'hBA, 8, rx);
    a = start;
    for (int k = 0; k < nwords; k++) begin
      w = {2'b00, ram_f(a)};
      for (int b = 0; b < 4; b++) begin
        spi_bits(8'h00, 8, rx);
        check(tag, rx, w[31-8*b -: 8]);
      end
      a = a + 18'd1;
    end
    cs_end();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  d8;
    logic [31:0] dw;
    int          n;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] rx;
    int         base_cnt;

    vecs[0] = '{8'h00, 8'h00, 32'h0,        2, 64'hAAFF_0000_0000_0000};
    vecs[1] = '{8'hB8, 8'h5C, 32'h0,        2, 64'h5CFF_0000_0000_0000};
    vecs[2] = '{8'hB9, 8'h00, 32'hDEADBEEF, 5, 64'hDEAD_BEEF_FF00_0000};
    vecs[3] = '{8'hB9, 8'h00, 32'h01234567, 4, 64'h0123_4567_0000_0000};
    vecs[4] = '{8'h3C, 8'h00, 32'h0,        2, 64'hFFFF_0000_0000_0000};
`ifdef SPI_WORD_COUNT_EN
    vecs[5] = '{8'hBD, 8'h00, 32'h0,        2, 64'h0000_0000_0000_0000};
`else
    vecs[5] = '{8'hBD, 8'h00, 32'h0,        2, 64'hFFFF_0000_0000_0000};
`endif
    vecs[6] = '{8'hB8, 8'hA5, 32'h0,        1, 64'hA500_0000_0000_0000};

    #23;
    check("reset_cipo", cipo, 1'b0);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_rd_addr", rd_addr, 18'h0);
    reset_n = 1'b1;
    #200;

    // Register replies; the latched source is inverted after decode.
    for (int v = 0; v < 7; v++) begin
      debug8  = vecs[v].d8;
      debug_w = vecs[v].dw;
      cs_start();
      spi_bits(vecs[v].op, 8, rx);
      check("opcode_cipo", rx, 8'hFF);
      debug8  = ~debug8;
      debug_w = ~debug_w;
      for (int b = 0; b < vecs[v].n; b++) begin
        spi_bits(8'h00, 8, rx);
        check($sformatf("vec%0d_byte%0d", v, b), rx, vecs[v].exp[63-8*b -: 8]);
      end
      cs_end();
    end

    // Address load then two-word burst; three read strobes.
    load_addr(24'h000123);
    addr_log.delete();
    base_cnt = rd_cnt;
    burst(18'h00123, 2, "burst_123");
    check("burst_rd_en_count", rd_cnt - base_cnt, 3);
    check("burst_first_addr", addr_log[0], 18'h00123);
    check("burst_second_addr", addr_log[1], 18'h00124);

    // Excess upper bits ignored; wrap from last word to 0.
    load_addr(24'hFFFFFF);
    addr_log.delete();
    burst(18'h3FFFF, 2, "burst_wrap");
    check("wrap_addr1", addr_log[1], 18'h00000);

    // Aborted address load after 1.5 payload bytes.
    cs_start();
    spi_bits(8'hBC, 8, rx);
    spi_bits(8'h01, 8, rx);
    check("abort_payload_cipo", rx, 8'hFF);
    spi_bits(8'h20, 4, rx);
    #HALF;
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_cipo", cipo, 1'b0);
    check("abort_rd_en", rd_en, 1'b0);
    #(4*HALF);
    burst(18'h3FFFF, 1, "abort_keep_base");

    // Asynchronous reset during a burst.
    load_addr(24'h000ABC);
    cs_start();
    spi_bits(8'hBA, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    #(HALF/2);
    reset_n = 1'b0;
    #1;
    check("rst_cipo", cipo, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 18'h0);
    cs = 1'b1;
    #200;
    reset_n = 1'b1;
    #200;
    burst(18'h00000, 1, "rst_base_zero");

`ifdef SPI_WORD_COUNT_EN
    // Five full words plus three bits, then read the count.
    load_addr(24'h000010);
    cs_start();
    spi_bits(8'hBA, 8, rx);
    for (int i = 0; i < 20; i++) spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 3, rx);
    cs_end();
    cs_start();
    spi_bits(8'hBD, 8, rx);
    spi_bits(8'h00, 8, rx);
    check("wc_msb", rx, 8'h00);
    spi_bits(8'h00, 8, rx);
    check("wc_lsb", rx, 8'h05);
    cs_end();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
